// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit: one request at a time over a req/ack data bus
// Aligns and extends load data into dram_rdo; builds byte-lane masks for stores.
module lsu_mem_port #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] dram_rdo,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wmask,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic          op_we;
    logic [2:0]    op_f3;
    logic [1:0]    op_lane;
    logic [CW-1:0] cnt;

    logic          is_byte;
    logic          is_half;
    logic          misaligned;
    logic [3:0]    new_mask;
    logic [31:0]   new_wdata;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_val;

    // Width comes from funct3[1:0]; the undefined encodings fall through to word width.
    always_comb begin
        is_byte = (funct3[1:0] == 2'b00);
        is_half = (funct3[1:0] == 2'b01);
        if (is_byte)
            misaligned = 1'b0;
        else if (is_half)
            misaligned = addr[0];
        else
            misaligned = (addr[1:0] != 2'b00);
    end

    always_comb begin
        new_mask  = 4'b0000;
        new_wdata = wdata;
        if (is_byte) begin
            new_wdata = {4{wdata[7:0]}};
            if (we)
                new_mask = 4'b0001 << addr[1:0];
        end else if (is_half) begin
            new_wdata = {2{wdata[15:0]}};
            if (we)
                new_mask = addr[1] ? 4'b1100 : 4'b0011;
        end else if (we) begin
            new_mask = 4'b1111;
        end
    end

    always_comb begin
        byte_v = bus_rdata[7:0];
        case (op_lane)
            2'd0: byte_v = bus_rdata[7:0];
            2'd1: byte_v = bus_rdata[15:8];
            2'd2: byte_v = bus_rdata[23:16];
            2'd3: byte_v = bus_rdata[31:24];
            default: byte_v = bus_rdata[7:0];
        endcase
        half_v = op_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_f3)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_val = {24'd0, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b101:  load_val = {16'd0, half_v};
            default: load_val = bus_rdata;
        endcase
    end

    assign stall = (req && (state != RESP)) || (state == BUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_f3     <= 3'd0;
            op_lane   <= 2'd0;
            cnt       <= '0;
            dram_rdo  <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wmask <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_we   <= we;
                        op_f3   <= funct3;
                        op_lane <= addr[1:0];
                        cnt     <= '0;
                        if (misaligned) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= we;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wmask <= new_mask;
                            bus_wdata <= new_wdata;
                        end
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        state   <= RESP;
                        done    <= 1'b1;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        cnt     <= '0;
                        if (!op_we)
                            dram_rdo <= load_val;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Last allowed bus cycle with no ack: give up and flag it.
                        state   <= RESP;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        cnt     <= '0;
                        if (!op_we)
                            dram_rdo <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
